// File: rtl/bias_stream_loader.sv
// Serial bias-word loader assembling N_adder_tree x 18-bit lanes into a packed bias bus.
// Optional shadow bank (atomic commit, q held during reload) enabled by BIAS_LOADER_DBUF_EN.
module bias_stream_loader #(
  parameter int N_adder_tree = 16,
  parameter int W            = 18
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_start,
  input  logic                      in_valid,
  input  logic [W-1:0]              in_data,
  output logic                      in_ready,
  input  logic                      layer_busy,
  output logic [N_adder_tree*W-1:0] q,
  output logic                      bank_valid,
  output logic                      load_done
);

  localparam int CW = $clog2(N_adder_tree);
  localparam logic [CW-1:0] LAST_LANE = CW'(N_adder_tree - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic                      in_ready_q, in_ready_d;
  logic                      load_done_q, load_done_d;
  logic                      bank_valid_q, bank_valid_d;
  logic [N_adder_tree*W-1:0] q_q, q_d;
`ifdef BIAS_LOADER_DBUF_EN
  logic [N_adder_tree*W-1:0] shadow_q, shadow_d;
`endif

  logic accept_s;
  logic last_s;
  logic start_s;
  logic commit_s;

  assign accept_s = in_valid & in_ready_q;
  assign last_s   = (cnt_q == LAST_LANE);
  assign start_s  = (state_q == IDLE) && (state_d == LOAD);
  assign commit_s = (state_q == COMMIT) && (state_d == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (load_start) state_d = LOAD;
        else            state_d = IDLE;
      end
      LOAD: begin
        if (accept_s && last_s) state_d = COMMIT;
        else                    state_d = LOAD;
      end
      COMMIT: begin
        if (!layer_busy) state_d = IDLE;
        else             state_d = COMMIT;
      end
      default: state_d = IDLE;
    endcase
  end

  // Without the shadow bank, accepted words land directly in q and bank_valid drops during LOAD.
  always_comb begin
    cnt_d        = cnt_q;
    in_ready_d   = (state_d == LOAD);
    load_done_d  = 1'b0;
    bank_valid_d = bank_valid_q;
    q_d          = q_q;
`ifdef BIAS_LOADER_DBUF_EN
    shadow_d     = shadow_q;
`endif

    if (start_s) begin
      cnt_d = '0;
`ifndef BIAS_LOADER_DBUF_EN
      bank_valid_d = 1'b0;
`endif
    end else if (accept_s && !last_s) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end

    if (accept_s) begin
`ifdef BIAS_LOADER_DBUF_EN
      shadow_d[int'(cnt_q)*W +: W] = in_data;
`else
      q_d[int'(cnt_q)*W +: W] = in_data;
`endif
    end else begin
      q_d = q_d;
    end

    if (commit_s) begin
      load_done_d  = 1'b1;
      bank_valid_d = 1'b1;
`ifdef BIAS_LOADER_DBUF_EN
      q_d = shadow_q;
`endif
    end else begin
      load_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      in_ready_q   <= 1'b0;
      load_done_q  <= 1'b0;
      bank_valid_q <= 1'b0;
      q_q          <= '0;
`ifdef BIAS_LOADER_DBUF_EN
      shadow_q     <= '0;
`endif
    end else begin
      cnt_q        <= cnt_d;
      in_ready_q   <= in_ready_d;
      load_done_q  <= load_done_d;
      bank_valid_q <= bank_valid_d;
      q_q          <= q_d;
`ifdef BIAS_LOADER_DBUF_EN
      shadow_q     <= shadow_d;
`endif
    end
  end

  assign in_ready   = in_ready_q;
  assign load_done  = load_done_q;
  assign bank_valid = bank_valid_q;
  assign q          = q_q;

endmodule

// File: tb/tb_bias_stream_loader.sv
// Randomized directed bench for bias_stream_loader against a transaction-level bias-bank model.
// Expectations follow BIAS_LOADER_DBUF_EN when the bench is built with it.
module tb_bias_stream_loader;
  localparam int N  = 16;
  localparam int BW = N * 18;
  typedef logic [17:0] word_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_start = 1'b0;
  logic          in_valid = 1'b0;
  logic [17:0]   in_data = 18'h0;
  logic          in_ready;
  logic          layer_busy = 1'b0;
  logic [BW-1:0] q;
  logic          bank_valid;
  logic          load_done;

  int total = 0;
  int bad   = 0;

  // Model: collected words, whether a load is collecting or awaiting commit, and the visible bank.
  word_t m_got[$];
  word_t m_lane[N];
  bit    m_loading = 1'b0;
  bit    m_pending = 1'b0;
  bit    m_bv = 1'b0;
  bit    m_done = 1'b0;

  word_t src[$];
  int n_acc, n_done, n_rdy, lat;

  bias_stream_loader #(.N_adder_tree(N), .W(18)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .layer_busy(layer_busy), .q(q), .bank_valid(bank_valid),
    .load_done(load_done)
  );

  always #5 clk = ~clk;

  function automatic logic [BW-1:0] pack_model();
    logic [BW-1:0] v = '0;
    for (int k = 0; k < N; k++) v[k*18 +: 18] = m_lane[k];
    return v;
  endfunction

  function automatic logic [BW-1:0] pack_src(input int cnt);
    logic [BW-1:0] v = '0;
    for (int k = 0; k < cnt; k++) v[k*18 +: 18] = src[k];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance the model over the coming edge, take the edge, then compare every output.
  task automatic tick();
    if (rst) begin
      m_loading = 1'b0; m_pending = 1'b0; m_got.delete(); m_bv = 1'b0; m_done = 1'b0;
      for (int k = 0; k < N; k++) m_lane[k] = 18'h0;
    end else begin
      m_done = 1'b0;
      if (m_pending) begin
        if (!layer_busy) begin
          m_pending = 1'b0;
`ifdef BIAS_LOADER_DBUF_EN
          for (int k = 0; k < N; k++) m_lane[k] = m_got[k];
`endif
          m_bv = 1'b1;
          m_done = 1'b1;
        end
      end else if (m_loading) begin
        if (in_valid) begin
`ifndef BIAS_LOADER_DBUF_EN
          m_lane[m_got.size()] = in_data;
`endif
          m_got.push_back(in_data);
          if (m_got.size() == N) begin
            m_loading = 1'b0;
            m_pending = 1'b1;
          end
        end
      end else if (load_start) begin
        m_loading = 1'b1;
        m_got.delete();
`ifndef BIAS_LOADER_DBUF_EN
        m_bv = 1'b0;
`endif
      end
    end
    @(posedge clk); #1;
    chk("in_ready", BW'(in_ready), BW'(m_loading));
    chk("load_done", BW'(load_done), BW'(m_done));
    chk("bank_valid", BW'(bank_valid), BW'(m_bv));
    chk("q", q, pack_model());
  endtask

  // Stream src into the loader; stop_at>=0 aborts after that many acceptances.
  task automatic do_load(input bit toggle, input int busy_cyc, input bit ls_spam, input int stop_at);
    word_t feed[$];
    int guard, busy_left, last_acc, done_cyc;
    bit acc_m;
    feed = src;
    n_acc = 0; n_done = 0; n_rdy = 0; lat = -1;
    last_acc = 0; done_cyc = 0; busy_left = busy_cyc;
    load_start = 1'b1;
    in_valid   = 1'b1;
    in_data    = feed[0];
    layer_busy = (busy_cyc > 0);
    tick();
    load_start = 1'b0;
    for (guard = 1; guard < 200; guard++) begin
      in_valid = (feed.size() > 0) && (!toggle || (guard % 2 == 1));
      in_data  = (feed.size() > 0) ? feed[0] : 18'h0;
      if (m_pending) begin
        layer_busy = (busy_left > 0);
        if (busy_left > 0) busy_left--;
      end else begin
        layer_busy = (busy_cyc > 0);
      end
      load_start = ls_spam && ((guard % 3 == 0) || (m_pending && !layer_busy));
      if (in_ready) n_rdy++;
      if (in_valid && in_ready) n_acc++;
      acc_m = in_valid && m_loading;
      tick();
      if (acc_m) begin
        void'(feed.pop_front());
        if (m_pending) last_acc = guard;
      end
      if (load_done) begin
        n_done++;
        done_cyc = guard;
      end
      if (stop_at >= 0 && n_acc == stop_at) break;
      if (m_done) break;
    end
    load_start = 1'b0;
    layer_busy = 1'b0;
    lat = done_cyc - last_acc;
    chk("load_bounded", BW'(guard < 200), BW'(1));
  endtask

  initial begin
    logic [BW-1:0] ones;
    int extra;
    for (int k = 0; k < N; k++) m_lane[k] = 18'h0;

    // Reset
    rst = 1'b1;
    tick(); tick();
    chk("rst_q", q, '0);
    chk("rst_bank_valid", BW'(bank_valid), BW'(0));
    chk("rst_in_ready", BW'(in_ready), BW'(0));
    chk("rst_load_done", BW'(load_done), BW'(0));
    rst = 1'b0;
    tick();

    // Test 1: contiguous load of k*0x100+0x54
    src.delete();
    for (int k = 0; k < N; k++) src.push_back(word_t'(k * 32'h100 + 32'h54));
    do_load(1'b0, 0, 1'b0, -1);
    chk("t1_ready_cycles", BW'(n_rdy), BW'(16));
    chk("t1_accepts", BW'(n_acc), BW'(16));
    chk("t1_done_pulses", BW'(n_done), BW'(1));
    chk("t1_latency", BW'(lat), BW'(1));
    chk("t1_lane0", BW'(q[17:0]), BW'(18'h00054));
    chk("t1_lane15", BW'(q[15*18 +: 18]), BW'(18'h00F54));
    chk("t1_q", q, pack_src(N));
    chk("t1_bank_valid", BW'(bank_valid), BW'(1));
    tick();
    chk("t1_done_single", BW'(load_done), BW'(0));

    // Test 2: backpressure with a 17th word left waiting
    src.delete();
    for (int k = 0; k < N + 1; k++) src.push_back(word_t'($urandom));
    do_load(1'b1, 0, 1'b0, -1);
    chk("t2_accepts", BW'(n_acc), BW'(16));
    chk("t2_done_pulses", BW'(n_done), BW'(1));
    chk("t2_q", q, pack_src(N));
    extra = 0;
    in_valid = 1'b1;
    in_data  = src[N];
    for (int c = 0; c < 4; c++) begin
      if (in_ready) extra++;
      tick();
    end
    chk("t2_no_17th", BW'(extra), BW'(0));
    in_valid = 1'b0;

    // Test 3: preload all-ones, then reload while layer_busy holds the commit for 5 cycles
    src.delete();
    for (int k = 0; k < N; k++) src.push_back(18'h3FFFF);
    do_load(1'b0, 0, 1'b0, -1);
    ones = q;
    chk("t3_preload", BW'(q[9*18 +: 18]), BW'(18'h3FFFF));
    src.delete();
    for (int k = 0; k < N; k++) src.push_back(word_t'($urandom));
    do_load(1'b0, 5, 1'b0, -1);
    chk("t3_latency", BW'(lat), BW'(6));
    chk("t3_done_pulses", BW'(n_done), BW'(1));
    chk("t3_q", q, pack_src(N));
    chk("t3_bank_valid", BW'(bank_valid), BW'(1));
    // Hold a commit off once more to look at q and bank_valid while it waits
    src.delete();
    for (int k = 0; k < N; k++) src.push_back(word_t'($urandom));
    do_load(1'b0, 5, 1'b0, 16);
    layer_busy = 1'b1;
    tick();
`ifdef BIAS_LOADER_DBUF_EN
    chk("t3_hold_q", q, pack_src(N) == ones ? ones : pack_model());
    chk("t3_hold_bv", BW'(bank_valid), BW'(1));
`else
    chk("t3_hold_q", q, pack_src(N));
    chk("t3_hold_bv", BW'(bank_valid), BW'(0));
`endif
    chk("t3_hold_done", BW'(load_done), BW'(0));
    layer_busy = 1'b0;
    tick();
    chk("t3_release_done", BW'(load_done), BW'(1));
    chk("t3_release_q", q, pack_src(N));

    // Test 4: reset after seven words, then a clean reload
    src.delete();
    for (int k = 0; k < N; k++) src.push_back(word_t'($urandom));
    do_load(1'b0, 0, 1'b0, 7);
    chk("t4_partial", BW'(n_acc), BW'(7));
    rst = 1'b1;
    in_valid = 1'b0;
    tick();
    chk("t4_rst_q", q, '0);
    chk("t4_rst_bv", BW'(bank_valid), BW'(0));
    chk("t4_rst_ready", BW'(in_ready), BW'(0));
    rst = 1'b0;
    tick();
    do_load(1'b0, 0, 1'b0, -1);
    chk("t4_reload_accepts", BW'(n_acc), BW'(16));
    chk("t4_reload_q", q, pack_src(N));

    // Test 5: load_start spam during LOAD/COMMIT, negative words in lanes 2 and 8
    src.delete();
    for (int k = 0; k < N; k++) src.push_back(word_t'($urandom));
    src[2] = 18'h3FDA8;
    src[8] = 18'h3DF64;
    do_load(1'b1, 3, 1'b1, -1);
    chk("t5_accepts", BW'(n_acc), BW'(16));
    chk("t5_done_pulses", BW'(n_done), BW'(1));
    chk("t5_lane2", BW'(q[2*18 +: 18]), BW'(18'h3FDA8));
    chk("t5_lane8", BW'(q[8*18 +: 18]), BW'(18'h3DF64));
    chk("t5_q", q, pack_src(N));
    in_valid = 1'b1;
    for (int c = 0; c < 3; c++) tick();
    chk("t5_stays_idle", BW'(in_ready), BW'(0));
    in_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
